riscv_multicycle_ctrl: RTL

Main control FSM for the multi-cycle RV32I core variant. It sequences fetch, decode, execute, memory and writeback over a single shared ALU and a single shared memory port, and drives the 2-bit ALUOp consumed by the ALU function decoder. It handles memory with a req/ready handshake, flags unsupported opcodes, and counts retired instructions.

---
 rtl/riscv_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback over one shared ALU and
// one shared memory port, flags unsupported opcodes and counts retirements.
module riscv_multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 branch,
    output logic                 pc_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 funct7_mask,
    output logic [1:0]           result_src,
    output logic                 reg_write,
    output logic                 illegal_instr,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ALUWB,
        ST_BRANCH,
        ST_JAL,
        ST_TRAP
    } state_e;

    state_e                 state_q, state_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   retire;

    // The zero flag qualifies the PC load inside the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: opcode dispatch in DECODE/MEMADR, memory waits hold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:    state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = ST_MEMADR;
                    OP_RTYPE:          state_d = ST_EXEC_R;
                    OP_ITYPE:          state_d = ST_EXEC_I;
                    OP_BRANCH:         state_d = ST_BRANCH;
                    OP_JAL:            state_d = ST_JAL;
                    default:           state_d = ST_TRAP;
                endcase
            end
            ST_MEMADR: state_d = (opcode == OP_LOAD) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
            ST_EXEC_R: state_d = ST_ALUWB;
            ST_EXEC_I: state_d = ST_ALUWB;
            ST_ALUWB:  state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JAL:    state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_RST;
        endcase
    end

    // Output decode from state; IR/PC load in FETCH and retire in MEMWR wait on mem_ready.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        funct7_mask   = 1'b0;
        result_src    = 2'b00;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        retire        = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b10;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            ST_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            ST_MEMRD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
            end
            ST_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            ST_MEMWR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
                retire       = mem_ready;
            end
            ST_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            ST_EXEC_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_op      = 2'b10;
                funct7_mask = 1'b1;
            end
            ST_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 1'b1;
                retire    = 1'b1;
            end
            ST_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                retire     = 1'b1;
            end
            ST_TRAP: begin
                illegal_instr = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Retired-instruction counter next value, wrapping modulo 2^INSTRET_W.
    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + INSTRET_W'(1);
        end
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

endmodule
